// File: rtl/sync_memory.sv
// Word-addressed synchronous memory with a fixed wait-state access FSM.
// After reset, INIT clears every word one per cycle before requests are accepted.
module sync_memory #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  busy,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  error
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t                  state, state_d;
    logic [3:0]              cnt, cnt_d;
    logic [IDX_W-1:0]        init_idx, init_idx_d;
    logic                    init_we;
    logic                    do_access;

    logic [ADDR_WIDTH-1:0]   address_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    error_q;
    logic                    in_range;
    logic [IDX_W-1:0]        idx;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Range check uses the full address so out-of-range words never alias.
    assign in_range = ({1'b0, address_q} < DEPTH_L);
    assign idx      = address_q[IDX_W-1:0];

    assign busy  = (state != IDLE);
    assign ack   = (state == DONE);
    assign error = ack & error_q;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        init_idx_d = init_idx;
        init_we    = 1'b0;
        do_access  = 1'b0;
        case (state)
            INIT: begin
                init_we    = 1'b1;
                init_idx_d = init_idx + IDX_W'(1);
                if (init_idx == IDX_W'(DEPTH - 1)) begin
                    state_d    = IDLE;
                    init_idx_d = '0;
                end
            end
            IDLE: begin
                if (req) begin
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else begin
                    do_access = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            cnt       <= '0;
            init_idx  <= '0;
            read_data <= '0;
            error_q   <= 1'b0;
            address_q <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            init_idx <= init_idx_d;
            if (state == IDLE && req) begin
                address_q <= address;
                we_q      <= write_enable;
                wdata_q   <= write_data;
            end
            if (do_access) begin
                error_q <= ~in_range;
                if (!we_q) begin
                    read_data <= in_range ? mem[idx] : '1;
                end
            end
        end
    end

    // Storage has no reset of its own; INIT performs the clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_we) begin
                mem[init_idx] <= '0;
            end else if (do_access && we_q && in_range) begin
                mem[idx] <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_sync_memory.sv
// Directed bench for sync_memory: one DUT with 2 wait states, one with none.
module tb_sync_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        busy, ack, error;
    logic [7:0]  rdata;
    logic        req0 = 1'b0, we0 = 1'b0;
    logic [15:0] addr0 = '0;
    logic [7:0]  wdata0 = '0;
    logic        busy0, ack0, error0;
    logic [7:0]  rdata0;

    int tests_run = 0;
    int failed = 0;

    always #5 clk = ~clk;

    sync_memory #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DEPTH(256), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .req(req), .write_enable(we), .address(addr),
        .write_data(wdata), .busy(busy), .ack(ack), .read_data(rdata), .error(error)
    );

    sync_memory #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DEPTH(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .write_enable(we0), .address(addr0),
        .write_data(wdata0), .busy(busy0), .ack(ack0), .read_data(rdata0), .error(error0)
    );

    // Issues one request; lat = edges from the latching edge until ack is seen.
    task automatic access(input bit sel, input logic w, input logic [15:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic er, output int lat,
                          output logic ack_nx, output logic err_nx);
        int guard = 0;
        while ((sel ? busy0 : busy) !== 1'b0 && guard < 600) begin
            @(posedge clk); #1; guard++;
        end
        if (sel) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else     begin req  = 1'b1; we  = w; addr  = a; wdata  = d; end
        @(posedge clk); #1;
        req = 1'b0; req0 = 1'b0;
        lat = 0;
        while ((sel ? ack0 : ack) !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 40) begin
            tests_run++; failed++;
            $display("FAIL ack_timeout addr=%h: no ack within 40 cycles", a);
        end
        rd = sel ? rdata0 : rdata;
        er = sel ? error0 : error;
        @(posedge clk); #1;
        ack_nx = sel ? ack0 : ack;
        err_nx = sel ? error0 : error;
    endtask

    task automatic test_reset;
        int n;
        logic [7:0] rd; logic er, an, en; int lat;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        tests_run++; if (busy !== 1'b1)   begin failed++; $display("FAIL reset_busy got=%b exp=1", busy); end
        tests_run++; if (ack !== 1'b0)    begin failed++; $display("FAIL reset_ack got=%b exp=0", ack); end
        tests_run++; if (error !== 1'b0)  begin failed++; $display("FAIL reset_error got=%b exp=0", error); end
        tests_run++; if (rdata !== 8'h00) begin failed++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        n = 1;
        @(posedge clk); #1;
        while (busy === 1'b1 && n < 400) begin n++; @(posedge clk); #1; end
        tests_run++; if (n !== 256) begin failed++; $display("FAIL init_busy_cycles got=%0d exp=256", n); end
        access(1'b0, 1'b0, 16'h0000, 8'h00, rd, er, lat, an, en);
        tests_run++; if (rd !== 8'h00) begin failed++; $display("FAIL init_read_0000 got=%h exp=00", rd); end
        tests_run++; if (er !== 1'b0)  begin failed++; $display("FAIL init_err_0000 got=%b exp=0", er); end
        access(1'b0, 1'b0, 16'h00FF, 8'h00, rd, er, lat, an, en);
        tests_run++; if (rd !== 8'h00) begin failed++; $display("FAIL init_read_00ff got=%h exp=00", rd); end
        tests_run++; if (er !== 1'b0)  begin failed++; $display("FAIL init_err_00ff got=%b exp=0", er); end
    endtask

    task automatic test_write_read;
        logic [7:0] rd; logic er, an, en; int lat;
        access(1'b0, 1'b1, 16'h0000, 8'hAA, rd, er, lat, an, en);
        tests_run++; if (er !== 1'b0) begin failed++; $display("FAIL wr0_err got=%b exp=0", er); end
        tests_run++; if (rd !== 8'h00) begin failed++; $display("FAIL wr0_rdata_held got=%h exp=00", rd); end
        access(1'b0, 1'b1, 16'h0001, 8'hBB, rd, er, lat, an, en);
        tests_run++; if (er !== 1'b0) begin failed++; $display("FAIL wr1_err got=%b exp=0", er); end
        access(1'b0, 1'b0, 16'h0000, 8'h00, rd, er, lat, an, en);
        tests_run++; if (rd !== 8'hAA) begin failed++; $display("FAIL rd0_data got=%h exp=aa", rd); end
        tests_run++; if (er !== 1'b0)  begin failed++; $display("FAIL rd0_err got=%b exp=0", er); end
        access(1'b0, 1'b0, 16'h0001, 8'h00, rd, er, lat, an, en);
        tests_run++; if (rd !== 8'hBB) begin failed++; $display("FAIL rd1_data got=%h exp=bb", rd); end
        tests_run++; if (er !== 1'b0)  begin failed++; $display("FAIL rd1_err got=%b exp=0", er); end
    endtask

    task automatic test_latency;
        logic [7:0] rd; logic er, an, en; int lat;
        access(1'b0, 1'b0, 16'h0001, 8'h00, rd, er, lat, an, en);
        tests_run++; if (lat !== 3)   begin failed++; $display("FAIL lat_ws2 got=%0d exp=3", lat); end
        tests_run++; if (an !== 1'b0) begin failed++; $display("FAIL ack_width_ws2 got=%b exp=0", an); end
        access(1'b1, 1'b1, 16'h0010, 8'h5A, rd, er, lat, an, en);
        tests_run++; if (lat !== 1)   begin failed++; $display("FAIL lat_ws0_wr got=%0d exp=1", lat); end
        tests_run++; if (an !== 1'b0) begin failed++; $display("FAIL ack_width_ws0 got=%b exp=0", an); end
        access(1'b1, 1'b0, 16'h0010, 8'h00, rd, er, lat, an, en);
        tests_run++; if (lat !== 1)    begin failed++; $display("FAIL lat_ws0_rd got=%0d exp=1", lat); end
        tests_run++; if (rd !== 8'h5A) begin failed++; $display("FAIL ws0_rdata got=%h exp=5a", rd); end
    endtask

    task automatic test_out_of_range;
        logic [7:0] rd; logic er, an, en; int lat;
        access(1'b0, 1'b1, 16'h0100, 8'h55, rd, er, lat, an, en);
        tests_run++; if (er !== 1'b1) begin failed++; $display("FAIL oor_wr_err got=%b exp=1", er); end
        tests_run++; if (en !== 1'b0) begin failed++; $display("FAIL oor_err_after_ack got=%b exp=0", en); end
        access(1'b0, 1'b0, 16'h0100, 8'h00, rd, er, lat, an, en);
        tests_run++; if (er !== 1'b1)  begin failed++; $display("FAIL oor_rd_err got=%b exp=1", er); end
        tests_run++; if (rd !== 8'hFF) begin failed++; $display("FAIL oor_rd_data got=%h exp=ff", rd); end
        access(1'b0, 1'b0, 16'h0000, 8'h00, rd, er, lat, an, en);
        tests_run++; if (rd !== 8'hAA) begin failed++; $display("FAIL oor_no_alias got=%h exp=aa", rd); end
        tests_run++; if (er !== 1'b0)  begin failed++; $display("FAIL oor_inrange_err got=%b exp=0", er); end
    endtask

    task automatic test_busy_collision;
        logic [7:0] rd; logic er, an, en; int lat;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 16'h0005; wdata = 8'h00;
        @(posedge clk); #1;
        // Keep a colliding write request asserted through WAIT and the access edge.
        we = 1'b1; addr = 16'h0002; wdata = 8'h11;
        repeat (3) begin @(posedge clk); #1; end
        req = 1'b0;
        tests_run++; if (ack !== 1'b1)   begin failed++; $display("FAIL coll_ack got=%b exp=1", ack); end
        tests_run++; if (rdata !== 8'h00) begin failed++; $display("FAIL coll_rdata got=%h exp=00", rdata); end
        @(posedge clk); #1;
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL coll_not_queued got=%b exp=0", busy); end
        access(1'b0, 1'b0, 16'h0002, 8'h00, rd, er, lat, an, en);
        tests_run++; if (rd !== 8'h00) begin failed++; $display("FAIL coll_read_0002 got=%h exp=00", rd); end
    endtask

    task automatic test_reset_mid_write;
        logic [7:0] rd; logic er, an, en; int lat;
        int n;
        logic seen_ack;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 16'h0003; wdata = 8'h77;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        tests_run++; if (ack !== 1'b0) begin failed++; $display("FAIL midwr_ack_wait got=%b exp=0", ack); end
        @(posedge clk); #1;
        reset = 1'b0;
        tests_run++; if (busy !== 1'b1) begin failed++; $display("FAIL midwr_busy got=%b exp=1", busy); end
        seen_ack = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            if (ack !== 1'b0) seen_ack = 1'b1;
            n++; @(posedge clk); #1;
        end
        tests_run++; if (seen_ack !== 1'b0) begin failed++; $display("FAIL midwr_no_ack got=%b exp=0", seen_ack); end
        tests_run++; if (n !== 256) begin failed++; $display("FAIL midwr_init_cycles got=%0d exp=256", n); end
        access(1'b0, 1'b0, 16'h0003, 8'h00, rd, er, lat, an, en);
        tests_run++; if (rd !== 8'h00) begin failed++; $display("FAIL midwr_read_0003 got=%h exp=00", rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency();
        test_out_of_range();
        test_busy_collision();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
